fpu_norm_arbiter: RTL

- Shares the single FPU normalize/round stage between the adder, multiplier and divider result streams.
- Each source pushes unnormalized results into a private FIFO. A round-robin arbiter issues at most one result per cycle into the normalizer, so no result is dropped when sources collide.
- Per-source almost-full flags let the FPU issue logic throttle the non-stallable pipelined units early enough.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_norm_arbiter_if.sv | 29 ++
 rtl/fpu_arb_fifo.sv | 49 ++++
 rtl/fpu_norm_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the FPU normalizer arbiter.
package fpu_pkg;
    localparam int FPU_NSRC = 3;
    typedef enum logic [1:0] {ADD = 2'd0, MULT = 2'd1, DIV = 2'd2} fpu_src_e;
    typedef struct packed {
        logic [26:0] mantissa;
        logic [7:0]  exponent;
        logic        sign;
        logic [4:0]  dest;
    } fpu_unnorm_t;
    function automatic fpu_src_e src_step(fpu_src_e s, logic [1:0] n);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, n};
        t = (t >= 3'd3) ? t - 3'd3 : t;
        return fpu_src_e'(t[1:0]);
    endfunction
endpackage

// File: rtl/fpu_norm_arbiter_if.sv
// fpu_norm_arbiter_if: source push streams and normalizer-side results.
interface fpu_norm_arbiter_if;
    logic        add_valid, mult_valid, div_valid;
    logic [26:0] add_mantissa, mult_mantissa, div_mantissa;
    logic [7:0]  add_exponent, mult_exponent, div_exponent;
    logic        add_sign, mult_sign, div_sign;
    logic [4:0]  add_dest, mult_dest, div_dest;
    logic        add_afull, mult_afull, div_afull;
    logic        norm_valid;
    logic [26:0] norm_mantissa;
    logic [7:0]  norm_exponent;
    logic        norm_sign;
    logic [4:0]  norm_dest;
    logic        overflow;
    modport master (
        output add_valid, mult_valid, div_valid, add_mantissa, mult_mantissa, div_mantissa,
               add_exponent, mult_exponent, div_exponent, add_sign, mult_sign, div_sign,
               add_dest, mult_dest, div_dest,
        input  add_afull, mult_afull, div_afull, norm_valid, norm_mantissa, norm_exponent,
               norm_sign, norm_dest, overflow
    );
    modport slave (
        input  add_valid, mult_valid, div_valid, add_mantissa, mult_mantissa, div_mantissa,
               add_exponent, mult_exponent, div_exponent, add_sign, mult_sign, div_sign,
               add_dest, mult_dest, div_dest,
        output add_afull, mult_afull, div_afull, norm_valid, norm_mantissa, norm_exponent,
               norm_sign, norm_dest, overflow
    );
endinterface

// File: rtl/fpu_arb_fifo.sv
// fpu_arb_fifo: per-source result FIFO; pushes into a full FIFO are dropped.
module fpu_arb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AFULL_MARGIN = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  fpu_unnorm_t   din,
    output fpu_unnorm_t   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          afull
);
    fpu_unnorm_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;
    logic [CW-1:0] count_nx;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign wr       = push && !full;
    assign rd       = pop && !empty;
    assign count_nx = count + CW'(wr) - CW'(rd);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clock)
        if (wr) mem[wr_ptr] <= din;

    // afull tracks the post-update count so it is ready the cycle after the crossing push
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count_nx;
            afull  <= count_nx >= CW'(DEPTH - AFULL_MARGIN);
        end
endmodule

// File: rtl/fpu_norm_arbiter.sv
// fpu_norm_arbiter: round-robin sharing of the normalize/round stage by add/mult/div FIFOs.
// Define FPU_ARB_STATS_EN to add conflict and peak-occupancy statistics outputs.
module fpu_norm_arbiter
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic clock,
    input  logic resetn,
    fpu_norm_arbiter_if.slave bus
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [31:0] stat_conflict,
    output logic [3*($clog2(DEPTH)+1)-1:0] stat_maxocc
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FPU_NSRC-1:0] push, pop, full, empty, afull;
    fpu_unnorm_t         din [FPU_NSRC];
    fpu_unnorm_t         head [FPU_NSRC];
    logic [CW-1:0]       cnt [FPU_NSRC];
    fpu_src_e            rr, gnt;
    logic                gnt_valid;
    fpu_unnorm_t         norm_q;
    logic                norm_valid, overflow;

    assign push   = {bus.div_valid, bus.mult_valid, bus.add_valid};
    assign din[0] = {bus.add_mantissa, bus.add_exponent, bus.add_sign, bus.add_dest};
    assign din[1] = {bus.mult_mantissa, bus.mult_exponent, bus.mult_sign, bus.mult_dest};
    assign din[2] = {bus.div_mantissa, bus.div_exponent, bus.div_sign, bus.div_dest};

    for (genvar i = 0; i < FPU_NSRC; i++) begin : g_fifo
        fpu_arb_fifo #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) u_fifo (
            .clock (clock),
            .resetn(resetn),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .head  (head[i]),
            .count (cnt[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .afull (afull[i])
        );
    end

    // Scan from the farthest offset down so the nearest non-empty source after rr wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = rr;
        for (int i = FPU_NSRC - 1; i >= 0; i--)
            if (!empty[src_step(rr, 2'(i))]) begin
                gnt_valid = 1'b1;
                gnt       = src_step(rr, 2'(i));
            end
    end

    assign pop = gnt_valid ? FPU_NSRC'(1) << gnt : '0;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            rr         <= ADD;
            norm_valid <= 1'b0;
            norm_q     <= '0;
            overflow   <= 1'b0;
        end else begin
            norm_valid <= gnt_valid;
            overflow   <= overflow | |(push & full);
            if (gnt_valid) begin
                norm_q <= head[gnt];
                rr     <= src_step(gnt, 2'd1);
            end
        end

    assign bus.norm_valid    = norm_valid;
    assign bus.norm_mantissa = norm_q.mantissa;
    assign bus.norm_exponent = norm_q.exponent;
    assign bus.norm_sign     = norm_q.sign;
    assign bus.norm_dest     = norm_q.dest;
    assign bus.overflow      = overflow;
    assign bus.add_afull     = afull[ADD];
    assign bus.mult_afull    = afull[MULT];
    assign bus.div_afull     = afull[DIV];

`ifdef FPU_ARB_STATS_EN
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            stat_conflict <= '0;
            stat_maxocc   <= '0;
        end else begin
            if ($countones(~empty) > 1 && stat_conflict != '1)
                stat_conflict <= stat_conflict + 32'd1;
            for (int i = 0; i < FPU_NSRC; i++)
                if (cnt[i] > stat_maxocc[i*CW +: CW])
                    stat_maxocc[i*CW +: CW] <= cnt[i];
        end
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt[0], cnt[1], cnt[2]};
`endif
endmodule
